// File: rtl/dram_write_ctrl.sv
// Write-side bridge from the page packer to the MIG 7-series app_* interface.
// Each accepted page becomes one write command and one write-data beat; the
// two are handed off independently, each under its own ready.
module dram_write_ctrl #(
   parameter int MEM_IF_WIDTH = 128,
   parameter int ADX_WIDTH    = 27,
   parameter int ALIGN_BITS   = 3
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [MEM_IF_WIDTH-1:0]   dram_data,
   input  logic [ADX_WIDTH-1:0]      dram_adx,
   input  logic                      write_req,
   output logic                      write_allowed,
   input  logic                      init_calib_complete,
   input  logic                      app_rdy,
   input  logic                      app_wdf_rdy,
   output logic                      app_en,
   output logic [2:0]                app_cmd,
   output logic [ADX_WIDTH-1:0]      app_addr,
   output logic [MEM_IF_WIDTH-1:0]   app_wdf_data,
   output logic                      app_wdf_wren,
   output logic                      app_wdf_end,
   output logic [MEM_IF_WIDTH/8-1:0] app_wdf_mask,
   output logic                      busy,
   output logic [31:0]               write_count,
   output logic                      overflow_err,
   output logic                      align_err
);

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic                    cmd_pend_q, cmd_pend_d;
   logic                    data_pend_q, data_pend_d;
   logic [ADX_WIDTH-1:0]    addr_q, addr_d;
   logic [MEM_IF_WIDTH-1:0] data_q, data_d;
   logic [31:0]             count_q, count_d;
   logic                    overflow_q, overflow_d;
   logic                    align_q, align_d;

   // Acceptance depends only on state and calibration, never on write_req.
   assign write_allowed = (state_q == IDLE) & init_calib_complete;

   assign app_en       = cmd_pend_q;
   assign app_cmd      = 3'b000;
   assign app_addr     = addr_q;
   assign app_wdf_data = data_q;
   assign app_wdf_wren = data_pend_q;
   assign app_wdf_end  = data_pend_q;
   assign app_wdf_mask = '0;
   assign busy         = (state_q == ISSUE);
   assign write_count  = count_q;
   assign overflow_err = overflow_q;
   assign align_err    = align_q;

   // Next-state: capture a page in IDLE, retire command and data independently in ISSUE.
   always_comb begin
      state_d     = state_q;
      cmd_pend_d  = cmd_pend_q;
      data_pend_d = data_pend_q;
      addr_d      = addr_q;
      data_d      = data_q;
      count_d     = count_q;
      overflow_d  = overflow_q | (write_req & ~write_allowed);
      align_d     = align_q;
      case (state_q)
         IDLE: begin
            if (write_req & write_allowed) begin
               addr_d      = dram_adx;
               data_d      = dram_data;
               cmd_pend_d  = 1'b1;
               data_pend_d = 1'b1;
               state_d     = ISSUE;
               // Misaligned addresses are flagged but still written as given.
               if (|dram_adx[ALIGN_BITS-1:0]) begin
                  align_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            if (app_rdy) begin
               cmd_pend_d = 1'b0;
            end
            if (app_wdf_rdy) begin
               data_pend_d = 1'b0;
            end
            // The page is done once both halves have been taken by the MIG.
            if (!cmd_pend_d && !data_pend_d) begin
               state_d = IDLE;
               count_d = count_q + 32'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and holding registers; reset drops any page in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         cmd_pend_q  <= 1'b0;
         data_pend_q <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         align_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_pend_q  <= cmd_pend_d;
         data_pend_q <= data_pend_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         align_q     <= align_d;
      end
   end

endmodule

// File: tb/tb_dram_write_ctrl.sv
// Self-checking bench for dram_write_ctrl: directed scenarios plus a random
// back-pressure stream, compared against a page-count reference model.
module tb_dram_write_ctrl;

   localparam int MW = 128;
   localparam int AW = 27;

   logic            clk = 1'b0;
   logic            resetn;
   logic [MW-1:0]   dram_data;
   logic [AW-1:0]   dram_adx;
   logic            write_req;
   logic            write_allowed;
   logic            init_calib_complete;
   logic            app_rdy;
   logic            app_wdf_rdy;
   logic            app_en;
   logic [2:0]      app_cmd;
   logic [AW-1:0]   app_addr;
   logic [MW-1:0]   app_wdf_data;
   logic            app_wdf_wren;
   logic            app_wdf_end;
   logic [MW/8-1:0] app_wdf_mask;
   logic            busy;
   logic [31:0]     write_count;
   logic            overflow_err;
   logic            align_err;

   dram_write_ctrl #(.MEM_IF_WIDTH(MW), .ADX_WIDTH(AW), .ALIGN_BITS(3)) dut (
      .clk(clk), .resetn(resetn), .dram_data(dram_data), .dram_adx(dram_adx),
      .write_req(write_req), .write_allowed(write_allowed),
      .init_calib_complete(init_calib_complete), .app_rdy(app_rdy),
      .app_wdf_rdy(app_wdf_rdy), .app_en(app_en), .app_cmd(app_cmd),
      .app_addr(app_addr), .app_wdf_data(app_wdf_data),
      .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
      .app_wdf_mask(app_wdf_mask), .busy(busy), .write_count(write_count),
      .overflow_err(overflow_err), .align_err(align_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: pages accepted, commands and data beats taken by the MIG.
   int            n_acc, n_cmd, n_data;
   logic [AW-1:0] pg_addr[$];
   logic [MW-1:0] pg_data[$];
   logic [AW-1:0] last_addr;
   logic [MW-1:0] last_data;
   logic          exp_ovf, exp_align;

   task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int pages_done();
      return (n_cmd < n_data) ? n_cmd : n_data;
   endfunction

   function automatic bit model_allowed();
      return init_calib_complete && (n_acc == pages_done());
   endfunction

   task automatic model_reset();
      n_acc = 0; n_cmd = 0; n_data = 0;
      pg_addr.delete(); pg_data.delete();
      last_addr = '0; last_data = '0;
      exp_ovf = 1'b0; exp_align = 1'b0;
   endtask

   task automatic compare_all();
      bit m_busy;
      m_busy = (n_acc > pages_done());
      check("app_en",        MW'(app_en),        MW'(n_cmd < n_acc));
      check("app_wdf_wren",  MW'(app_wdf_wren),  MW'(n_data < n_acc));
      check("app_wdf_end",   MW'(app_wdf_end),   MW'(n_data < n_acc));
      check("busy",          MW'(busy),          MW'(m_busy));
      check("write_allowed", MW'(write_allowed), MW'(init_calib_complete && !m_busy));
      check("write_count",   MW'(write_count),   MW'(pages_done()));
      check("overflow_err",  MW'(overflow_err),  MW'(exp_ovf));
      check("align_err",     MW'(align_err),     MW'(exp_align));
      check("app_addr",      MW'(app_addr),      MW'(last_addr));
      check("app_wdf_data",  app_wdf_data,       last_data);
      check("app_cmd",       MW'(app_cmd),       MW'(0));
      check("app_wdf_mask",  MW'(app_wdf_mask),  MW'(0));
   endtask

   // One clock: update the model from pre-edge signals, then check post-edge outputs.
   task automatic tick();
      bit allowed;
      allowed = model_allowed();
      if (app_en && app_rdy) begin
         check("cmd_expected", MW'(n_cmd < n_acc), MW'(1));
         if (n_cmd < n_acc) check("cmd_addr_order", MW'(app_addr), MW'(pg_addr[n_cmd]));
         n_cmd++;
      end
      if (app_wdf_wren && app_wdf_rdy) begin
         check("data_expected", MW'(n_data < n_acc), MW'(1));
         if (n_data < n_acc) check("data_order", app_wdf_data, pg_data[n_data]);
         n_data++;
      end
      if (write_req && !allowed) exp_ovf = 1'b1;
      if (write_req && allowed) begin
         pg_addr.push_back(dram_adx);
         pg_data.push_back(dram_data);
         last_addr = dram_adx;
         last_data = dram_data;
         if (dram_adx[2:0] != 3'd0) exp_align = 1'b1;
         n_acc++;
      end
      @(posedge clk);
      #1;
      compare_all();
      $display("tick t=%0t req=%0b en=%0b wren=%0b busy=%0b count=%0d", $time,
               write_req, app_en, app_wdf_wren, busy, write_count);
   endtask

   initial begin
      int budget;
      model_reset();
      resetn = 1'b0; write_req = 1'b0; init_calib_complete = 1'b0;
      app_rdy = 1'b0; app_wdf_rdy = 1'b0; dram_adx = '0; dram_data = '0;

      // Reset with calibration pending.
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      resetn = 1'b1;
      tick(); tick();
      check("calib_gate", MW'(write_allowed), MW'(0));

      // Calibration completes.
      init_calib_complete = 1'b1;
      tick();
      check("calib_allowed", MW'(write_allowed), MW'(1));

      // Single write with the MIG always ready.
      app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      dram_adx = 27'h0000010;
      dram_data = 128'h0123456789ABCDEF0123456789ABCDEF;
      write_req = 1'b1;
      tick();
      write_req = 1'b0;
      check("single_en", MW'(app_en), MW'(1));
      check("single_addr", MW'(app_addr), MW'(27'h10));
      tick();
      check("single_en_drop", MW'(app_en), MW'(0));
      check("single_count", MW'(write_count), MW'(1));
      check("single_reopen", MW'(write_allowed), MW'(1));
      tick();

      // Command stalled for 5 cycles, data taken immediately.
      app_rdy = 1'b0; app_wdf_rdy = 1'b1;
      dram_adx = 27'h0000020; dram_data = {4{$urandom}};
      write_req = 1'b1;
      tick();
      write_req = 1'b0;
      repeat (5) tick();
      check("cmd_stall_en", MW'(app_en), MW'(1));
      check("cmd_stall_count", MW'(write_count), MW'(1));
      app_rdy = 1'b1;
      tick();
      check("cmd_stall_done", MW'(write_count), MW'(2));

      // Data stalled for 5 cycles, command taken immediately.
      app_rdy = 1'b1; app_wdf_rdy = 1'b0;
      dram_adx = 27'h0000028; dram_data = {4{$urandom}};
      write_req = 1'b1;
      tick();
      write_req = 1'b0;
      repeat (5) tick();
      check("data_stall_wren", MW'(app_wdf_wren), MW'(1));
      app_wdf_rdy = 1'b1;
      tick();
      check("data_stall_done", MW'(write_count), MW'(3));

      // Request while busy raises a sticky overflow; misaligned address flags align_err.
      app_rdy = 1'b0; app_wdf_rdy = 1'b0;
      dram_adx = 27'h0000005; dram_data = {4{$urandom}};
      write_req = 1'b1;
      tick();
      check("align_flag", MW'(align_err), MW'(1));
      check("align_addr", MW'(app_addr), MW'(27'h5));
      dram_adx = 27'h0000030;
      tick();
      write_req = 1'b0;
      check("overflow_flag", MW'(overflow_err), MW'(1));
      app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      tick(); tick();
      check("overflow_sticky", MW'(overflow_err), MW'(1));
      check("overflow_no_extra", MW'(write_count), MW'(4));

      // Asynchronous reset while a command is stalled.
      app_rdy = 1'b0; app_wdf_rdy = 1'b0;
      dram_adx = 27'h0000040; dram_data = {4{$urandom}};
      write_req = 1'b1;
      tick();
      write_req = 1'b0;
      check("pre_reset_en", MW'(app_en), MW'(1));
      resetn = 1'b0;
      #1;
      check("rst_app_en", MW'(app_en), MW'(0));
      check("rst_wren", MW'(app_wdf_wren), MW'(0));
      check("rst_busy", MW'(busy), MW'(0));
      check("rst_count", MW'(write_count), MW'(0));
      model_reset();
      @(posedge clk);
      #1;
      resetn = 1'b1;
      compare_all();

      // Random back-pressure stream of 100 pages from a well-behaved packer.
      budget = 0;
      while ((n_acc < 100 || n_acc > pages_done()) && budget < 3000) begin
         app_rdy     = $urandom_range(0, 1) == 1;
         app_wdf_rdy = $urandom_range(0, 1) == 1;
         dram_adx    = AW'(n_acc * 8);
         dram_data   = {$urandom, $urandom, $urandom, $urandom};
         write_req   = (n_acc < 100) && model_allowed();
         tick();
         budget++;
      end
      write_req = 1'b0;
      check("stream_budget", MW'(budget < 3000), MW'(1));
      check("stream_count", MW'(write_count), MW'(100));
      check("stream_cmds", MW'(n_cmd), MW'(100));
      check("stream_beats", MW'(n_data), MW'(100));
      check("stream_overflow", MW'(overflow_err), MW'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
